// File: rtl/sprite_palette_engine_if.sv
// Pixel request, palette write, blink control and pixel output bundle
// for the sprite palette engine.
`timescale 1ns/1ps
interface sprite_palette_engine_if #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PAL_W = 2
) ();
    logic              valid_in;
    logic [PAL_W-1:0]  pal_sel;
    logic [IDX_W-1:0]  index;
    logic              wr_en;
    logic [PAL_W-1:0]  wr_pal;
    logic [IDX_W-1:0]  wr_idx;
    logic [11:0]       wr_rgb;
    logic              frame_tick;
    logic              flash_start;
    logic [7:0]        flash_frames;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              transparent;
    logic              valid_out;
    logic              flashing;

    modport master (
        output valid_in, pal_sel, index, wr_en, wr_pal, wr_idx, wr_rgb,
               frame_tick, flash_start, flash_frames,
        input  red, green, blue, transparent, valid_out, flashing
    );

    modport slave (
        input  valid_in, pal_sel, index, wr_en, wr_pal, wr_idx, wr_rgb,
               frame_tick, flash_start, flash_frames,
        output red, green, blue, transparent, valid_out, flashing
    );
endinterface

// File: rtl/sprite_palette_engine.sv
// Multi-palette sprite colour lookup with a 2-stage pipeline and a
// frame-timed blink FSM that forces opaque pixels to white while on.
`timescale 1ns/1ps
module sprite_palette_engine #(
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned NUM_PAL      = 4,
    parameter int unsigned PAL_W        = 2,
    parameter int unsigned TRANSP_IDX   = 0,
    parameter int unsigned FLASH_PERIOD = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    sprite_palette_engine_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned RGB_W = 12;
    localparam int unsigned PH_W  = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam logic [RGB_W-1:0] WHITE = 12'hFFF;

    typedef struct packed {
        logic [RGB_W-1:0] rgb;
        logic             transp;
    } pix_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2
    } state_t;

    logic [RGB_W-1:0] pal_mem [NUM_PAL][DEPTH];

    logic             wr_ok;
    logic             rd_ok;
    logic [RGB_W-1:0] rd_rgb;
    pix_t             s1_pix;
    logic             s1_valid;

    state_t           state, state_n;
    logic [7:0]       remaining, remaining_n;
    logic [PH_W-1:0]  phase, phase_n;

    assign wr_ok  = bus.wr_en && (32'(bus.wr_pal) < NUM_PAL);
    assign rd_ok  = 32'(bus.pal_sel) < NUM_PAL;
    assign rd_rgb = rd_ok ? pal_mem[bus.pal_sel][bus.index] : '0;

    // Palette storage; a same-cycle read sees the pre-write value
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int p = 0; p < int'(NUM_PAL); p++) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    pal_mem[p][i] <= '0;
                end
            end
        end else if (wr_ok) begin
            pal_mem[bus.wr_pal][bus.wr_idx] <= bus.wr_rgb;
        end
    end

    // Stage 1: raw lookup and transparency
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
        end else begin
            s1_valid      <= bus.valid_in;
            s1_pix.rgb    <= rd_rgb;
            s1_pix.transp <= rd_ok && (bus.index == IDX_W'(TRANSP_IDX));
        end
    end

    // Stage 2: flash override uses the FSM state at this edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.valid_out   <= 1'b0;
            bus.transparent <= 1'b0;
            bus.red         <= '0;
            bus.green       <= '0;
            bus.blue        <= '0;
        end else begin
            bus.valid_out <= s1_valid;
            if (s1_valid) begin
                bus.transparent <= s1_pix.transp;
                if ((state == FLASH_ON) && !s1_pix.transp) begin
                    {bus.red, bus.green, bus.blue} <= WHITE;
                end else begin
                    {bus.red, bus.green, bus.blue} <= s1_pix.rgb;
                end
            end else begin
                bus.transparent <= 1'b0;
                bus.red         <= '0;
                bus.green       <= '0;
                bus.blue        <= '0;
            end
        end
    end

    // Blink FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            remaining    <= '0;
            phase        <= '0;
            bus.flashing <= 1'b0;
        end else begin
            state        <= state_n;
            remaining    <= remaining_n;
            phase        <= phase_n;
            bus.flashing <= (state_n != IDLE);
        end
    end

    // Blink next-state; a start request overrides a coincident tick
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        phase_n     = phase;
        if (bus.flash_start) begin
            phase_n = '0;
            if (bus.flash_frames != 8'd0) begin
                state_n     = FLASH_ON;
                remaining_n = bus.flash_frames;
            end else begin
                state_n     = IDLE;
                remaining_n = '0;
            end
        end else if (bus.frame_tick && (state != IDLE)) begin
            remaining_n = remaining - 8'd1;
            if (remaining == 8'd1) begin
                state_n = IDLE;
                phase_n = '0;
            end else if (phase == PH_W'(FLASH_PERIOD - 1)) begin
                phase_n = '0;
                state_n = (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
            end else begin
                phase_n = phase + PH_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sprite_palette_engine.sv
// Scoreboard bench for sprite_palette_engine: expected pixels are queued
// when requested and compared as valid_out delivers them.
`timescale 1ns/1ps
module tb_sprite_palette_engine;
    typedef struct packed {
        logic [11:0] rgb;
        logic        t;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    logic mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    sprite_palette_engine_if #(.IDX_W(4), .PAL_W(2)) bus ();

    sprite_palette_engine #(
        .IDX_W(4), .NUM_PAL(3), .PAL_W(2), .TRANSP_IDX(0), .FLASH_PERIOD(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    task automatic idle_inputs();
        bus.valid_in     = 1'b0;
        bus.pal_sel      = '0;
        bus.index        = '0;
        bus.wr_en        = 1'b0;
        bus.wr_pal       = '0;
        bus.wr_idx       = '0;
        bus.wr_rgb       = '0;
        bus.frame_tick   = 1'b0;
        bus.flash_start  = 1'b0;
        bus.flash_frames = '0;
    endtask

    task automatic step();
        @(negedge Clk);
        idle_inputs();
    endtask

    task automatic px(input logic [1:0] ps, input logic [3:0] ix,
                      input logic [11:0] er, input logic et);
        bus.valid_in = 1'b1;
        bus.pal_sel  = ps;
        bus.index    = ix;
        q.push_back('{rgb: er, t: et});
    endtask

    task automatic wr(input logic [1:0] wp, input logic [3:0] wi, input logic [11:0] wd);
        bus.wr_en  = 1'b1;
        bus.wr_pal = wp;
        bus.wr_idx = wi;
        bus.wr_rgb = wd;
    endtask

    task automatic flash(input logic [7:0] frames);
        bus.flash_start  = 1'b1;
        bus.flash_frames = frames;
    endtask

    task automatic drain();
        repeat (4) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pixels never delivered, want 0", q.size());
            q.delete();
        end
    endtask

    // Blink of 10 frames, half-period 4: on for 0-3 ticks, off 4-7, on 8-9
    function automatic logic [11:0] flash_exp(input int t);
        return (t < 10 && ((t / 4) % 2) == 0) ? 12'hFFF : 12'h6DF;
    endfunction

    // Scoreboard monitor
    initial begin
        forever begin
            exp_t e;
            @(posedge Clk);
            #1;
            if (mon_en) begin
                checks++;
                if (bus.valid_out) begin
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL pix_unexpected: valid_out=1 rgb=%h, want no pixel",
                                 {bus.red, bus.green, bus.blue});
                    end else begin
                        e = q.pop_front();
                        if ({bus.red, bus.green, bus.blue, bus.transparent} !== {e.rgb, e.t}) begin
                            errors++;
                            $display("FAIL pix: got rgb=%h t=%b, want rgb=%h t=%b",
                                     {bus.red, bus.green, bus.blue}, bus.transparent, e.rgb, e.t);
                        end
                    end
                end else if ({bus.red, bus.green, bus.blue, bus.transparent} !== 13'd0) begin
                    errors++;
                    $display("FAIL idle_zero: got rgb=%h t=%b, want 000/0",
                             {bus.red, bus.green, bus.blue}, bus.transparent);
                end
            end
        end
    end

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        step();
        step();
        checks++;
        if ({bus.red, bus.green, bus.blue, bus.transparent, bus.valid_out, bus.flashing} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rgb=%h t=%b v=%b f=%b, want all 0",
                     {bus.red, bus.green, bus.blue}, bus.transparent, bus.valid_out, bus.flashing);
        end
        Reset  = 1'b0;
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_basic();
        wr(2'd1, 4'd4, 12'h6DF);
        step();
        wr(2'd0, 4'd15, 12'h9B3);
        step();
        px(2'd1, 4'd4, 12'h6DF, 1'b0);
        step();
        checks++;
        if (bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid_out=%b after 1 edge, want 0", bus.valid_out);
        end
        step();
        checks++;
        if (bus.valid_out !== 1'b1 || {bus.red, bus.green, bus.blue} !== 12'h6DF) begin
            errors++;
            $display("FAIL latency_2: valid_out=%b rgb=%h, want 1/6df",
                     bus.valid_out, {bus.red, bus.green, bus.blue});
        end
        px(2'd0, 4'd15, 12'h9B3, 1'b0);
        step();
        px(2'd0, 4'd4, 12'h000, 1'b0);
        step();
        drain();
    endtask

    task automatic test_transparency();
        wr(2'd2, 4'd0, 12'h0A5);
        step();
        px(2'd2, 4'd0, 12'h0A5, 1'b1);
        step();
        px(2'd3, 4'd4, 12'h000, 1'b0);
        step();
        px(2'd3, 4'd0, 12'h000, 1'b0);
        step();
        wr(2'd3, 4'd5, 12'hFFF);
        step();
        px(2'd0, 4'd5, 12'h000, 1'b0);
        step();
        px(2'd1, 4'd5, 12'h000, 1'b0);
        step();
        drain();
    endtask

    task automatic test_collision();
        wr(2'd0, 4'd1, 12'h123);
        px(2'd0, 4'd1, 12'h000, 1'b0);
        step();
        px(2'd0, 4'd1, 12'h123, 1'b0);
        step();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0: px(2'd1, 4'd4, 12'h6DF, 1'b0);
                1: px(2'd0, 4'd15, 12'h9B3, 1'b0);
                2: px(2'd2, 4'd0, 12'h0A5, 1'b1);
                default: px(2'd3, 4'd2, 12'h000, 1'b0);
            endcase
            step();
        end
        drain();
    endtask

    task automatic test_flash();
        flash(8'd10);
        px(2'd1, 4'd4, flash_exp(0), 1'b0);
        step();
        checks++;
        if (bus.flashing !== 1'b1) begin
            errors++;
            $display("FAIL flash_start: flashing=%b, want 1", bus.flashing);
        end
        for (int t = 1; t <= 10; t++) begin
            bus.frame_tick = 1'b1;
            px(2'd1, 4'd4, flash_exp(t), 1'b0);
            step();
            checks++;
            if (bus.flashing !== (t < 10)) begin
                errors++;
                $display("FAIL flash_tick%0d: flashing=%b, want %b", t, bus.flashing, (t < 10));
            end
            repeat (2) begin
                px(2'd1, 4'd4, flash_exp(t), 1'b0);
                step();
            end
        end
        drain();
    endtask

    task automatic test_restart();
        flash(8'd10);
        px(2'd1, 4'd4, 12'hFFF, 1'b0);
        step();
        repeat (2) begin
            bus.frame_tick = 1'b1;
            px(2'd1, 4'd4, 12'hFFF, 1'b0);
            step();
        end
        flash(8'd3);
        bus.frame_tick = 1'b1;
        px(2'd1, 4'd4, 12'hFFF, 1'b0);
        step();
        px(2'd2, 4'd0, 12'h0A5, 1'b1);
        step();
        for (int k = 1; k <= 3; k++) begin
            bus.frame_tick = 1'b1;
            px(2'd1, 4'd4, (k < 3) ? 12'hFFF : 12'h6DF, 1'b0);
            step();
            checks++;
            if (bus.flashing !== (k < 3)) begin
                errors++;
                $display("FAIL restart_tick%0d: flashing=%b, want %b", k, bus.flashing, (k < 3));
            end
        end
        flash(8'd5);
        px(2'd1, 4'd4, 12'hFFF, 1'b0);
        step();
        flash(8'd0);
        px(2'd1, 4'd4, 12'h6DF, 1'b0);
        step();
        checks++;
        if (bus.flashing !== 1'b0) begin
            errors++;
            $display("FAIL cancel: flashing=%b, want 0", bus.flashing);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        flash(8'd20);
        px(2'd1, 4'd4, 12'hFFF, 1'b0);
        step();
        drain();
        mon_en = 1'b0;
        checks++;
        if (bus.flashing !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_flashing: flashing=%b, want 1", bus.flashing);
        end
        bus.valid_in = 1'b1;
        bus.pal_sel  = 2'd1;
        bus.index    = 4'd4;
        step();
        bus.valid_in = 1'b1;
        bus.pal_sel  = 2'd1;
        bus.index    = 4'd4;
        Reset = 1'b1;
        step();
        checks++;
        if ({bus.red, bus.green, bus.blue, bus.transparent, bus.valid_out, bus.flashing} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset: got rgb=%h t=%b v=%b f=%b, want all 0",
                     {bus.red, bus.green, bus.blue}, bus.transparent, bus.valid_out, bus.flashing);
        end
        Reset = 1'b0;
        q.delete();
        mon_en = 1'b1;
        px(2'd1, 4'd4, 12'h000, 1'b0);
        step();
        px(2'd2, 4'd0, 12'h000, 1'b1);
        step();
        drain();
        checks++;
        if (bus.flashing !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_flashing: flashing=%b, want 0", bus.flashing);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_transparency();
        test_collision();
        test_back_to_back();
        test_flash();
        test_restart();
        test_reset_mid();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
